// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter and the UART it feeds.
// State encoding is fixed so debug probes and future RX dispatch can decode it.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_e;

    localparam int NREQ_DEF    = 4;
    localparam int IDX_W_DEF   = 2;
    localparam int BUSY_TO_DEF = 8;

    // System clock is 16x oversampling of 9600 baud.
    localparam int CLK_HZ     = 153600;
    localparam int BAUD       = 9600;
    localparam int OVERSAMPLE = CLK_HZ / BAUD;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req_i at or above rr_ptr_i, modulo NREQ.
// Shared with the receive-side dispatcher, so it carries no state of its own.
module uart_rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] winner_o,
    output logic             valid_o
);

    int best_d;
    int d;

    // Each requester's distance from the pointer; the smallest distance wins.
    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        best_d   = NREQ;
        d        = 0;
        for (int i = 0; i < NREQ; i++) begin
            d = (i + NREQ - (int'(rr_ptr_i) % NREQ)) % NREQ;
            if (req_i[i] && (d < best_d)) begin
                best_d   = d;
                winner_o = IDX_W'(i);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources.
// Define UART_TX_ARBITER_LOCK_EN to add lock_i, which keeps a multi-byte message contiguous.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int IDX_W   = IDX_W_DEF,
    parameter int BUSY_TO = BUSY_TO_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [8*NREQ-1:0] req_data_i,
`ifdef UART_TX_ARBITER_LOCK_EN
    input  logic [NREQ-1:0]   lock_i,
`endif
    output logic [NREQ-1:0]   ack_o,
    output logic [7:0]        tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic [IDX_W-1:0]  gnt_idx_o,
    output logic              err_to_o,
    output logic [1:0]        dbg_state_o
);

    localparam int CNT_W = $clog2(BUSY_TO + 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [NREQ-1:0]  ack_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic             err_to_q;
`ifdef UART_TX_ARBITER_LOCK_EN
    logic             gnt_vld_q;
`endif

    logic [IDX_W-1:0] rr_win;
    logic             rr_vld;
    logic [IDX_W-1:0] win_idx_d;
    logic             win_vld_d;
    logic             win_adv_d;
    logic [7:0]       tx_data_d;
    logic [NREQ-1:0]  ack_d;
    logic [IDX_W-1:0] rr_ptr_d;

    uart_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req_i    (req_i),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (rr_win),
        .valid_o  (rr_vld)
    );

    always_comb begin
        win_idx_d = rr_win;
        win_vld_d = rr_vld;
        win_adv_d = 1'b1;
`ifdef UART_TX_ARBITER_LOCK_EN
        // A locked previous winner that still requests jumps ahead of the pointer.
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld_q && (IDX_W'(i) == gnt_idx_q) && req_i[i] && lock_i[i]) begin
                win_idx_d = gnt_idx_q;
                win_vld_d = 1'b1;
                win_adv_d = 1'b0;
            end
        end
`endif
        tx_data_d = 8'h00;
        ack_d     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == win_idx_d) begin
                tx_data_d = req_data_i[8*i +: 8];
                ack_d[i]  = 1'b1;
            end
        end
        rr_ptr_d = IDX_W'(rr_next(int'(win_idx_d), NREQ));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            ack_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            gnt_idx_q  <= '0;
            err_to_q   <= 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
            gnt_vld_q  <= 1'b0;
`endif
        end else begin
            ack_q      <= '0;
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!tx_busy_i && win_vld_d) begin
                        tx_data_q  <= tx_data_d;
                        ack_q      <= ack_d;
                        tx_start_q <= 1'b1;
                        gnt_idx_q  <= win_idx_d;
                        if (win_adv_d) rr_ptr_q <= rr_ptr_d;
                        cnt_q      <= '0;
                        state_q    <= ST_WAIT_BUSY;
`ifdef UART_TX_ARBITER_LOCK_EN
                        gnt_vld_q  <= 1'b1;
`endif
                    end
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        cnt_q   <= '0;
                        state_q <= ST_WAIT_DONE;
                    end else if (cnt_q == CNT_W'(BUSY_TO - 1)) begin
                        // UART never answered: byte is dropped, ack was already given.
                        err_to_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack_o       = ack_q;
    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = tx_start_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign err_to_o    = err_to_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART and queued requesters.
// Build with UART_TX_ARBITER_LOCK_EN defined to exercise lock_i.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  lock;
    logic [3:0]  ack_o;
    logic [7:0]  tx_data_o;
    logic        tx_start_o;
    logic        tx_busy;
    logic [1:0]  gnt_idx_o;
    logic        err_to_o;
    logic [1:0]  dbg_state_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = -100;
    int frame_len = 160;
    bit uart_dead = 1'b0;

    logic [9:0] exp_q[$];
    logic [9:0] pend_q[$];

    uart_tx_arbiter #(.NREQ(4), .IDX_W(2), .BUSY_TO(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_data_i  (req_data),
`ifdef UART_TX_ARBITER_LOCK_EN
        .lock_i      (lock),
`endif
        .ack_o       (ack_o),
        .tx_data_o   (tx_data_o),
        .tx_start_o  (tx_start_o),
        .tx_busy_i   (tx_busy),
        .gnt_idx_o   (gnt_idx_o),
        .err_to_o    (err_to_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit_reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // UART model: busy rises one cycle after tx_start and holds for frame_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start_o === 1'b1 && !uart_dead) begin
                tx_busy = 1'b1;
                repeat (frame_len) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    // Requester driver: each requester holds its oldest pending byte until acked.
    always @(negedge clk) begin
        logic [9:0] p;
        for (int i = 0; i < 4; i++) begin
            if (ack_o[i] === 1'b1) begin
                for (int j = 0; j < pend_q.size(); j++) begin
                    p = pend_q[j];
                    if (p[9:8] == 2'(i)) begin
                        pend_q.delete(j);
                        break;
                    end
                end
            end
        end
        req      = '0;
        req_data = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < pend_q.size(); j++) begin
                p = pend_q[j];
                if (p[9:8] == 2'(i)) begin
                    req[i]             = 1'b1;
                    req_data[8*i +: 8] = p[7:0];
                    break;
                end
            end
        end
    end

    // Scoreboard monitor: every start/ack pops one expected {index, byte}.
    always @(negedge clk) begin
        logic [9:0] e;
        cyc++;
        if (tx_start_o === 1'b1 || (ack_o !== 4'b0000 && ack_o !== 4'bxxxx)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start actual data=%0h gnt=%0d ack=%b expected none",
                         tx_data_o, gnt_idx_o, ack_o);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", 32'(tx_data_o), 32'(e[7:0]));
                check("gnt_idx", 32'(gnt_idx_o), 32'(e[9:8]));
                check("ack_onehot", 32'(ack_o), 32'(4'b0001 << e[9:8]));
                check("tx_start_with_ack", 32'(tx_start_o), 32'd1);
                check("start_spacing_ge3", 32'(cyc - last_start >= 3), 32'd1);
            end
            last_start = cyc;
        end
    end

    task automatic sync_in();
        @(posedge clk);
        #2;
    endtask

    function automatic void add_req(input int r, input logic [7:0] b);
        pend_q.push_back({2'(r), b});
    endfunction

    function automatic void expect_tx(input int r, input logic [7:0] b);
        exp_q.push_back({2'(r), b});
    endfunction

    task automatic drain(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && pend_q.size() == 0 && dbg_state_o == 2'd0 && !tx_busy) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain actual pending=%0d expected_left=%0d required 0/0",
                     name, pend_q.size(), exp_q.size());
            exp_q.delete();
            pend_q.delete();
        end
    endtask

    task automatic wait_state(input string name, input logic [1:0] st);
        bit hit = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (dbg_state_o == st) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s_state_wait actual=%0d expected=%0d", name, dbg_state_o, st);
        end
    endtask

    task automatic check_reset(input string name);
        check({name, "_ack"}, 32'(ack_o), 32'd0);
        check({name, "_tx_data"}, 32'(tx_data_o), 32'h00);
        check({name, "_tx_start"}, 32'(tx_start_o), 32'd0);
        check({name, "_gnt_idx"}, 32'(gnt_idx_o), 32'd0);
        check({name, "_err_to"}, 32'(err_to_o), 32'd0);
        check({name, "_state"}, 32'(dbg_state_o), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit found;
        bit b;
        rst_n     = 1'b0;
        lock      = 4'b0000;
        uart_dead = 1'b0;
        frame_len = 160;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Single request from requester 0, long frame.
        sync_in();
        add_req(0, 8'hAA);
        expect_tx(0, 8'hAA);
        drain("single");
        check("single_gnt_idx", 32'(gnt_idx_o), 32'd0);

        // All four requesters, pointer starts at 0 and wraps 3 -> 0.
        apply_reset();
        frame_len = 20;
        sync_in();
        add_req(0, 8'h10);
        add_req(1, 8'h20);
        add_req(2, 8'h30);
        add_req(3, 8'h40);
        add_req(0, 8'h10);
        expect_tx(0, 8'h10);
        expect_tx(1, 8'h20);
        expect_tx(2, 8'h30);
        expect_tx(3, 8'h40);
        expect_tx(0, 8'h10);
        drain("all_four");
        check("wrap_gnt_idx", 32'(gnt_idx_o), 32'd0);

        // Request arriving in WAIT_DONE waits; grant lands one cycle after busy falls.
        sync_in();
        add_req(0, 8'h55);
        expect_tx(0, 8'h55);
        wait_state("late_req", 2'd2);
        sync_in();
        add_req(2, 8'h77);
        expect_tx(2, 8'h77);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            b = tx_busy;
            #1;
            if (b) begin
                check("late_req_hold", 32'(tx_start_o), 32'd0);
            end else begin
                check("late_req_no_same_edge", 32'(tx_start_o), 32'd0);
                found = 1'b1;
                break;
            end
        end
        check("late_req_busy_fell", 32'(found), 32'd1);
        @(posedge clk);
        #1;
        check("late_req_grant_next", 32'(tx_start_o), 32'd1);
        drain("late_req");

        // UART never answers: err_to after 8 cycles, then next request still served.
        uart_dead = 1'b1;
        sync_in();
        add_req(1, 8'h5A);
        expect_tx(1, 8'h5A);
        found = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (tx_start_o) begin
                found = 1'b1;
                break;
            end
        end
        check("timeout_start_seen", 32'(found), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k < 8) check("timeout_not_yet", 32'(err_to_o), 32'd0);
        end
        check("timeout_err_to", 32'(err_to_o), 32'd1);
        check("timeout_back_idle", 32'(dbg_state_o), 32'd0);
        uart_dead = 1'b0;
        sync_in();
        add_req(2, 8'h66);
        expect_tx(2, 8'h66);
        drain("after_timeout");
        check("err_to_sticky", 32'(err_to_o), 32'd1);

        // Reset mid-frame with busy high: outputs clear, no grant until busy drops.
        sync_in();
        add_req(3, 8'h99);
        expect_tx(3, 8'h99);
        wait_state("midreset", 2'd2);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("midreset");
        check("midreset_busy_still_high", 32'(tx_busy), 32'd1);
        sync_in();
        add_req(0, 8'h11);
        expect_tx(0, 8'h11);
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            b = tx_busy;
            #1;
            if (b) begin
                check("midreset_hold", 32'(tx_start_o), 32'd0);
            end else begin
                check("midreset_grant_when_free", 32'(tx_start_o), 32'd1);
                found = 1'b1;
                break;
            end
        end
        check("midreset_busy_fell", 32'(found), 32'd1);
        drain("midreset");

        // Requester 1 sends three bytes with lock high while requester 3 waits.
        lock = 4'b0010;
        sync_in();
        add_req(1, 8'hA1);
        add_req(1, 8'hA2);
        add_req(1, 8'hA3);
        add_req(3, 8'hB3);
`ifdef UART_TX_ARBITER_LOCK_EN
        expect_tx(1, 8'hA1);
        expect_tx(1, 8'hA2);
        expect_tx(1, 8'hA3);
        expect_tx(3, 8'hB3);
`else
        expect_tx(1, 8'hA1);
        expect_tx(3, 8'hB3);
        expect_tx(1, 8'hA2);
        expect_tx(1, 8'hA3);
`endif
        drain("lock");
`ifdef UART_TX_ARBITER_LOCK_EN
        check("lock_last_gnt", 32'(gnt_idx_o), 32'd3);
`else
        check("lock_last_gnt", 32'(gnt_idx_o), 32'd1);
`endif
        lock = 4'b0000;

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NREQ byte sources using round-robin arbitration.
- Sequences the UART transmit path: latches the winner's byte, pulses the UART's transmit-start input, and tracks tx_busy until the frame ends.
- Sits between system requesters (status reporter, debug console, loopback echo, and so on) and the UART instance.
- Timing is based on the 153 600 Hz system clock (16x 9600 baud).

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDX_W, 2, index width; must be at least clog2(NREQ).
- BUSY_TO, 8, clock cycles allowed for tx_busy to rise after tx_start before the attempt is abandoned.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req  in  NREQ  per-requester byte-pending flag; held until ack.
- req_data  in  8*NREQ  byte from requester i at [8i+7:8i]; stable while req[i] is high.
- ack  out  NREQ  one-hot, one-cycle pulse: byte accepted.
- tx_data  out  8  byte to the UART; stable from tx_start until the frame ends.
- tx_start  out  1  one-cycle pulse to the UART transmit-start input.
- tx_busy  in  1  UART frame in progress.
- gnt_idx  out  IDX_W  index of the last granted requester.
- err_to  out  1  sticky flag: tx_busy did not rise within BUSY_TO cycles.

Behaviour:
- Reset values: ack=0, tx_data=8'h00, tx_start=0, gnt_idx=0, err_to=0, state=IDLE, rr_ptr=0, timeout counter=0.
- States: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - A grant is made only when the registered state is IDLE, tx_busy=0 and |req=1.
  - Winner is the first requester with req high, searching from rr_ptr upward modulo NREQ.
  - On that edge: tx_data<=winner's byte; ack[winner]<=1; tx_start<=1; gnt_idx<=winner; rr_ptr<=(winner+1) mod NREQ; state->WAIT_BUSY.
- Latency: a request sampled in IDLE produces ack and tx_start high together in the next cycle, for exactly one cycle.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE and clear the counter.
  - Otherwise increment the counter.
  - When the counter reaches BUSY_TO-1 with tx_busy still 0: set err_to, go to IDLE. The byte is lost; ack has already been given.
- WAIT_DONE: when tx_busy=0, go to IDLE. The earliest regrant is the following cycle.
- Minimum spacing between tx_start pulses is 3 cycles. A requester may drop req or change req_data on any edge after it sees ack.
- Requests arriving outside IDLE are held pending; none are lost.
- A req dropped before grant is simply not served.
- Simultaneous requests: rr_ptr decides. Every active requester is served within NREQ grants.
- rr_ptr wrap-around: NREQ-1 is followed by 0.
- tx_busy already high in IDLE (after reset mid-frame, or a UART started externally): no grant is made until it falls.
- Reset mid-operation: all registers return to reset values on the next edge. No tx_start is issued during reset. A UART frame already in flight is not aborted.
- err_to clears only on reset.

Optional Feature:
- Macro: UART_TX_ARBITER_LOCK_EN.
- When defined:
  - Adds input lock (NREQ bits).
  - If the last granted requester has lock and req both high when the arbiter re-enters IDLE, it is granted again, ahead of rr_ptr. rr_ptr is not advanced. This keeps multi-byte messages contiguous.
  - lock without req is ignored.
  - Lock is never preempted; starvation is the requester's responsibility.
- When undefined: no lock port; pure round-robin.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2), default NREQ/BUSY_TO constants, and the baud/clock constants already shared by the UART.
- One sub-module: uart_rr_pick. Purely combinational; inputs req and rr_ptr; outputs winner index and a valid flag. Reused by future RX dispatch.

Test Plan:
- Reset then a single request: req=4'b0001, byte 8'hAA, UART model raises busy 1 cycle after start and holds it for 160 cycles -> one tx_start with tx_data=8'hAA, ack[0] pulses once, gnt_idx=0.
- All four requesters active, bytes 8'h10/8'h20/8'h30/8'h40 -> tx_data order 10,20,30,40, then 10 again; rr_ptr wraps from 3 to 0.
- req[2] raised while a frame is in WAIT_DONE -> no tx_start until busy falls; grant 1 cycle after busy falls.
- UART model never raises busy -> err_to=1 after BUSY_TO=8 cycles; state returns to IDLE; next request is still served.
- rst_n low for 2 cycles mid-frame while busy is high -> outputs return to reset values; no grant until busy drops.
- With UART_TX_ARBITER_LOCK_EN defined: req[1] with lock[1] for 3 bytes, req[3] also pending -> bytes 1,1,1 are sent, then requester 3.
